cfg_chain_sequencer: RTL

Sequences loading of the FPGA fabric configuration shift chain between the wishbone-facing word buffer and the serial config chain. It accepts 32-bit bitstream words over a valid/ready stream and serialises them LSB-first onto the chain with a programmable bit-rate divider. After the commanded bit count it pulses the chain's set/latch strobe. It sits between the wishbone slave registers and the fabric chain, one instance per chain.

---
 rtl/cfg_chain_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/cfg_chain_sequencer.sv
// Config chain sequencer: takes bitstream words over valid/ready, shifts them
// LSB-first onto the fabric chain at a programmable rate, then pulses the latch strobe.
module cfg_chain_sequencer #(
  parameter int WORD_W     = 32,
  parameter int LEN_W      = 20,
  parameter int DIV_W      = 8,
  parameter int SET_CYCLES = 4
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              shift_out,
  output logic              shift_en,
  output logic              set_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // state | meaning
  // IDLE  | waiting for cfg_start
  // LOAD  | word_ready high, waiting for next bitstream word
  // SHIFT | serialising current word, one bit per divider period
  // SET   | latch strobe held for SET_CYCLES cycles
  // DONE  | one-cycle completion pulse
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_SET, S_DONE} state_t;

  localparam int WB_W = $clog2(WORD_W + 1);
  localparam int SC_W = $clog2(SET_CYCLES + 1);

  state_t            r_state;
  logic [LEN_W-1:0]  r_remaining;
  logic [DIV_W-1:0]  r_div;
  logic [DIV_W-1:0]  r_div_cnt;
  logic [WORD_W-1:0] r_sreg;
  logic [WB_W-1:0]   r_word_bits;
  logic [SC_W-1:0]   r_set_cnt;
  logic              r_shift_out;
  logic              r_shift_en;
  logic              r_set_out;
  logic              r_done;
  logic              r_err;

  logic [WB_W-1:0]   w_first_bits;
  logic [DIV_W-1:0]  w_div_nxt;

  assign w_first_bits = (r_remaining > LEN_W'(WORD_W)) ? WB_W'(WORD_W) : WB_W'(r_remaining);
  assign w_div_nxt    = r_div_cnt + DIV_W'(1);

  // r_shift_en is kept equal to (SHIFT && r_div_cnt == r_div) by predicting it one cycle ahead
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || cfg_abort) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_div       <= '0;
      r_div_cnt   <= '0;
      r_sreg      <= '0;
      r_word_bits <= '0;
      r_set_cnt   <= '0;
      r_shift_out <= 1'b0;
      r_shift_en  <= 1'b0;
      r_set_out   <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cfg_start) begin
            if (cfg_len == '0) begin
              r_err <= 1'b1;
            end else begin
              r_remaining <= cfg_len;
              r_div       <= cfg_div;
              r_state     <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (word_valid) begin
            r_sreg      <= word_data;
            r_word_bits <= w_first_bits;
            r_shift_out <= word_data[0];
            r_div_cnt   <= '0;
            r_shift_en  <= (r_div == '0);
            r_state     <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (r_shift_en) begin
            r_sreg      <= r_sreg >> 1;
            r_remaining <= r_remaining - LEN_W'(1);
            r_word_bits <= r_word_bits - WB_W'(1);
            r_div_cnt   <= '0;
            if (r_remaining == LEN_W'(1)) begin
              r_shift_en  <= 1'b0;
              r_shift_out <= 1'b0;
              r_set_out   <= 1'b1;
              r_set_cnt   <= '0;
              r_state     <= S_SET;
            end else if (r_word_bits == WB_W'(1)) begin
              r_shift_en  <= 1'b0;
              r_shift_out <= 1'b0;
              r_state     <= S_LOAD;
            end else begin
              r_shift_out <= r_sreg[1];
              r_shift_en  <= (r_div == '0);
            end
          end else begin
            r_div_cnt  <= w_div_nxt;
            r_shift_en <= (w_div_nxt == r_div);
          end
        end
        S_SET: begin
          if (r_set_cnt == SC_W'(SET_CYCLES - 1)) begin
            r_set_out <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_set_cnt <= r_set_cnt + SC_W'(1);
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign word_ready = (r_state == S_LOAD);
  assign busy       = (r_state != S_IDLE);
  assign shift_out  = r_shift_out;
  assign shift_en   = r_shift_en;
  assign set_out    = r_set_out;
  assign done       = r_done;
  assign err        = r_err;

endmodule
